// File: rtl/trace_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : trace_gen_if
// Description : Bundle between the core pipeline and the trace source.
//               The core (master) drives the fetch/hazard/writeback signals,
//               and the trace source (slave) drives the retirement record.
//               trace_count exists only when TRACE_CNT_EN is defined.
// Ports       : if_instr, if_valid, stall, flush, wb_we, wb_rd_value (core)
//               trace_valid, trace_instruction, trace_rd, trace_rs1,
//               trace_rs2, trace_imm, trace_rd_value, [trace_count] (trace)
// Revision    : 1.0 - initial release
// ============================================================================
interface trace_gen_if;
   logic [31:0]        if_instr;
   logic               if_valid;
   logic               stall;
   logic               flush;
   logic               wb_we;
   logic [31:0]        wb_rd_value;

   logic               trace_valid;
   logic [31:0]        trace_instruction;
   logic [4:0]         trace_rd;
   logic [4:0]         trace_rs1;
   logic [4:0]         trace_rs2;
   logic signed [11:0] trace_imm;
   logic signed [31:0] trace_rd_value;
`ifdef TRACE_CNT_EN
   logic [31:0]        trace_count;

   modport master (
      output if_instr, if_valid, stall, flush, wb_we, wb_rd_value,
      input  trace_valid, trace_instruction, trace_rd, trace_rs1, trace_rs2,
             trace_imm, trace_rd_value, trace_count
   );
   modport slave (
      input  if_instr, if_valid, stall, flush, wb_we, wb_rd_value,
      output trace_valid, trace_instruction, trace_rd, trace_rs1, trace_rs2,
             trace_imm, trace_rd_value, trace_count
   );
`else
   modport master (
      output if_instr, if_valid, stall, flush, wb_we, wb_rd_value,
      input  trace_valid, trace_instruction, trace_rd, trace_rs1, trace_rs2,
             trace_imm, trace_rd_value
   );
   modport slave (
      input  if_instr, if_valid, stall, flush, wb_we, wb_rd_value,
      output trace_valid, trace_instruction, trace_rd, trace_rs1, trace_rs2,
             trace_imm, trace_rd_value
   );
`endif
endinterface
`default_nettype wire

// File: rtl/trace_gen.sv
`default_nettype none
// ============================================================================
// Module      : trace_gen
// Description : Trace source for the 5-stage RISC-V core. Carries a tag
//               {valid, instr} through D/E/M/W alongside the datapath,
//               honouring stalls (bubble into E) and flushes (squash D),
//               decodes the instruction at W and registers one retirement
//               record per instruction on the trace bus.
// Ports       : clk   - core clock, rising edge
//               rst_n - asynchronous active-low reset
//               tg    - trace_gen_if.slave (pipeline inputs, trace outputs)
// Config      : TRACE_CNT_EN - adds the 32-bit wrapping retire counter
//               trace_count
// Revision    : 1.0 - initial release
// ============================================================================
module trace_gen (
   input  wire logic   clk,
   input  wire logic   rst_n,
   trace_gen_if.slave  tg
);

   localparam logic [6:0] c_op_r      = 7'b0110011;
   localparam logic [6:0] c_op_imm    = 7'b0010011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_system = 7'b1110011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_auipc  = 7'b0010111;
   localparam logic [6:0] c_op_jal    = 7'b1101111;

   // Tag stages
   logic               r_d_valid, r_e_valid, r_m_valid, r_w_valid;
   logic [31:0]        r_d_instr, r_e_instr, r_m_instr, r_w_instr;

   // Registered record
   logic               r_trace_valid;
   logic [31:0]        r_trace_instr;
   logic [4:0]         r_trace_rd, r_trace_rs1, r_trace_rs2;
   logic signed [11:0] r_trace_imm;
   logic signed [31:0] r_trace_rd_value;

   // Decoded W-stage fields
   logic [6:0]         w_opcode;
   logic [4:0]         w_rd, w_rs1, w_rs2;
   logic signed [11:0] w_imm;
   logic signed [31:0] w_rd_value;

   // -------------------------------------------------------------------------
   // Tag pipeline. Flush beats stall: the instruction sitting in D is younger
   // than the branch in E and must vanish, while the branch itself moves on.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d_valid <= 1'b0;
         r_d_instr <= 32'd0;
         r_e_valid <= 1'b0;
         r_e_instr <= 32'd0;
         r_m_valid <= 1'b0;
         r_m_instr <= 32'd0;
         r_w_valid <= 1'b0;
         r_w_instr <= 32'd0;
      end else begin
         if (tg.flush) begin
            r_d_valid <= 1'b0;
            r_d_instr <= 32'd0;
            r_e_valid <= 1'b0;
            r_e_instr <= 32'd0;
         end else if (tg.stall) begin
            // D holds its instruction; E receives a bubble.
            r_e_valid <= 1'b0;
            r_e_instr <= 32'd0;
         end else begin
            r_d_valid <= tg.if_valid;
            r_d_instr <= tg.if_instr;
            r_e_valid <= r_d_valid;
            r_e_instr <= r_d_instr;
         end
         r_m_valid <= r_e_valid;
         r_m_instr <= r_e_instr;
         r_w_valid <= r_m_valid;
         r_w_instr <= r_m_instr;
      end
   end

   // -------------------------------------------------------------------------
   // W-stage decode. Fields a format does not use stay zero; an unknown
   // opcode decodes to all-zero fields but is still traced.
   // -------------------------------------------------------------------------
   assign w_opcode = r_w_instr[6:0];

   always_comb begin
      w_rd  = 5'd0;
      w_rs1 = 5'd0;
      w_rs2 = 5'd0;
      w_imm = 12'sd0;
      case (w_opcode)
         c_op_r: begin
            w_rd  = r_w_instr[11:7];
            w_rs1 = r_w_instr[19:15];
            w_rs2 = r_w_instr[24:20];
         end
         c_op_imm, c_op_load, c_op_jalr, c_op_system: begin
            w_rd  = r_w_instr[11:7];
            w_rs1 = r_w_instr[19:15];
            w_imm = r_w_instr[31:20];
         end
         c_op_store: begin
            w_rs1 = r_w_instr[19:15];
            w_rs2 = r_w_instr[24:20];
            w_imm = {r_w_instr[31:25], r_w_instr[11:7]};
         end
         c_op_branch: begin
            // Offset bits 12:1; bit 0 is implicitly zero and not carried.
            w_rs1 = r_w_instr[19:15];
            w_rs2 = r_w_instr[24:20];
            w_imm = {r_w_instr[31], r_w_instr[7], r_w_instr[30:25], r_w_instr[11:8]};
         end
         c_op_lui, c_op_auipc, c_op_jal: begin
            w_rd = r_w_instr[11:7];
         end
         default: begin
         end
      endcase
   end

   // Writes to x0 (or stores/branches, whose decoded rd is 0) report zero.
   assign w_rd_value = (tg.wb_we && (w_rd != 5'd0)) ? tg.wb_rd_value : 32'sd0;

   // -------------------------------------------------------------------------
   // Record register: fields update only on retirement, otherwise they hold
   // so the consumer sees a stable bus between pulses.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trace_valid    <= 1'b0;
         r_trace_instr    <= 32'd0;
         r_trace_rd       <= 5'd0;
         r_trace_rs1      <= 5'd0;
         r_trace_rs2      <= 5'd0;
         r_trace_imm      <= 12'sd0;
         r_trace_rd_value <= 32'sd0;
      end else begin
         r_trace_valid <= r_w_valid;
         if (r_w_valid) begin
            r_trace_instr    <= r_w_instr;
            r_trace_rd       <= w_rd;
            r_trace_rs1      <= w_rs1;
            r_trace_rs2      <= w_rs2;
            r_trace_imm      <= w_imm;
            r_trace_rd_value <= w_rd_value;
         end
      end
   end

   assign tg.trace_valid       = r_trace_valid;
   assign tg.trace_instruction = r_trace_instr;
   assign tg.trace_rd          = r_trace_rd;
   assign tg.trace_rs1         = r_trace_rs1;
   assign tg.trace_rs2         = r_trace_rs2;
   assign tg.trace_imm         = r_trace_imm;
   assign tg.trace_rd_value    = r_trace_rd_value;

`ifdef TRACE_CNT_EN
   logic [31:0] r_count;

   // Counts on the same edge that raises trace_valid; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 32'd0;
      end else if (r_w_valid) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign tg.trace_count = r_count;
`endif

endmodule
`default_nettype wire

// File: doc/trace_gen.md
# trace_gen

Trace source for the 5-stage RISC-V core. Tags each fetched instruction, carries it through ID/EX/MEM/WB alongside the datapath, and survives stalls and branch flushes. At retirement it presents one registered record per instruction on the `trace_*` bus. Fields are the instruction word, decoded rd/rs1/rs2/imm, and the written-back value. That bus is the exact input set consumed by the trace logger.

## Interface
- No parameters.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_instr` in 32: instruction word leaving IF.
- `if_valid` in 1: `if_instr` is a real instruction (0 = bubble).
- `stall` in 1: hazard stall; holds IF/ID, inserts bubble into EX.
- `flush` in 1: taken branch/jump resolved in EX; squashes younger entries.
- `wb_we` in 1: register-file write enable in WB this cycle.
- `wb_rd_value` in 32: value written back in WB this cycle.
- `trace_valid` out 1: record on `trace_*` is a retired instruction.
- `trace_instruction` out 32: retired instruction word.
- `trace_rd`, `trace_rs1`, `trace_rs2` out 5 each: decoded register fields.
- `trace_imm` out 12 (signed): decoded immediate.
- `trace_rd_value` out 32 (signed): written-back value.
- `trace_count` out 32: retire count (only with `TRACE_CNT_EN`).

## Operation
- Four tag stages: D, E, M, W. Each holds {valid, instr[31:0]}.
- Normal edge:
  - D <= {if_valid, if_instr}.
  - E <= D, M <= E, W <= M.
- Stall edge (flush=0):
  - D holds.
  - E <= bubble.
  - M <= E, W <= M.
- Flush edge:
  - D <= bubble.
  - E <= bubble; the instruction in D is squashed.
  - M <= E, so the branch itself retires; W <= M.
  - Flush has priority over stall.
- Decode happens at the W stage by opcode `instr[6:0]`. Fields not used by a format are 0.
  - R (0110011): rd, rs1, rs2; imm=0.
  - I (0010011, 0000011, 1100111, 1110011): rd, rs1; imm = `instr[31:20]`.
  - S (0100011): rs1, rs2; imm = {`instr[31:25]`, `instr[11:7]`}.
  - B (1100011): rs1, rs2; imm = {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`}, i.e. offset bits 12:1.
  - U (0110111, 0010111), J (1101111): rd only; imm=0.
  - Unknown opcode: all fields 0; the instruction is still traced.
- trace_rd_value:
  - = `wb_rd_value` if `wb_we`=1 and decoded rd≠0.
  - Otherwise 0.
- Record registration at the edge ending a cycle in which W is valid:
  - trace_valid <= 1.
  - All trace fields <= decoded W contents.
- When W is a bubble:
  - trace_valid <= 0.
  - All other trace outputs hold their previous values.

## Timing
- Reset: all tag valids = 0, instr = 0; every trace output = 0 (including `trace_count`).
- Reset is asynchronous. Assertion mid-pipeline discards all in-flight tags immediately; no record is emitted for them.
- Latency is 4 edges from capture into D to `trace_valid` high, with no stall or flush. Capture edge = edge 0; the record is visible after edge 4.
- Each stall cycle adds one edge of latency to D's instruction and produces one trace_valid=0 cycle downstream.
- `trace_valid` is a 1-cycle pulse per retired instruction. Back-to-back retirements give consecutive high cycles.
- `wb_we`/`wb_rd_value` are sampled only in the cycle W holds the instruction.
- No backpressure; the consumer must accept every record.

## Configuration
- `TRACE_CNT_EN` defined:
  - Adds `trace_count`, a 32-bit retire counter.
  - It increments on the same edge that sets trace_valid=1 and wraps from 0xFFFFFFFF to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then fetch `addi x5,x0,7` (0x00700293) with wb_we=1, wb_rd_value=7 in its WB cycle:
  - trace_valid high after edge 4.
  - rd=5, rs1=0, rs2=0, imm=7, rd_value=7.
- Fetch `sw x6,-4(x2)` (0xFE612E23):
  - rd=0, rs1=2, rs2=6, imm=-4, rd_value=0 even if wb_we=1.
- Three back-to-back R-type instructions with stall=1 for one cycle while the 2nd is in D:
  - Retire order 1,2,3 with exactly one trace_valid=0 cycle between records 1 and 2.
- Branch `beq x1,x2,+8` (0x00208463) in E with flush=1 and stall=1 simultaneously:
  - The branch retires with imm=4.
  - The two younger instructions never produce records.
- Assert rst_n=0 for one cycle with three valid tags in flight:
  - Outputs go to 0 asynchronously (before the next edge).
  - No records are emitted after release.
- With `TRACE_CNT_EN`, force the counter to 0xFFFFFFFE and retire 3 instructions: `trace_count` reads 0xFFFFFFFF, 0, 1.
